// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter.
//   - Read / write channel state encodings.
//   - Master index constants (icache, dcache, LSU uncached path).
//   - Line offset: an address's line number is addr[AW-1:LINE_OFS] (32-byte lines).
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_REQ  = 2'd1,
      R_DATA = 2'd2
   } rd_state_e;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_REQ  = 1'b1
   } wr_state_e;

   localparam int MST_ICACHE = 0;
   localparam int MST_DCACHE = 1;
   localparam int MST_LSU    = 2;

   localparam int LINE_OFS = 5;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector, one bit per master
//   ptr : highest-priority master index; scanning goes upward and wraps N-1 -> 0
//   gnt : one-hot grant (all zero when nothing is requesting)
//   idx : binary index of the granted master (0 when nothing is requesting)
module mem_port_arbiter_rr_pick #(
   parameter  int N  = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   always_comb begin
      int   c;
      logic found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      c     = 0;
      for (int k = 0; k < N; k++) begin
         if (!found) begin
            c = int'(ptr) + k;
            if (c >= N) begin
               c = c - N;
            end
            if (req[c]) begin
               found  = 1'b1;
               gnt[c] = 1'b1;
               idx    = IW'(c);
            end
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory-port arbiter: shares the single bridge request/response port among N
// masters (0 = icache, 1 = dcache, 2 = LSU uncached). Reads and writes are
// arbitrated independently, each with its own round-robin pointer and at most
// one transaction in flight per channel.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   m_r_req/addr/type -> m_r_rdy    per-master read request / accept pulse
//   m_re_data, m_re_valid           read response (data broadcast, valid to grantee)
//   m_w_req/addr/type/strb/data     per-master write request
//   m_w_rdy                         per-master write accept pulse
//   s_r_* / s_re_*                  bridge read request and response
//   s_w_*                           bridge write request
// A read is withheld from arbitration while a pending (un-accepted) write
// targets the same 32-byte line, so a read can never overtake that write.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int N  = 3,
   parameter int AW = 32,
   parameter int DW = 256,
   parameter int TW = 6,
   parameter int SW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    m_r_req,
   input  logic [N*AW-1:0] m_r_addr,
   input  logic [N*TW-1:0] m_r_type,
   output logic [N-1:0]    m_r_rdy,
   output logic [DW-1:0]   m_re_data,
   output logic [N-1:0]    m_re_valid,
   input  logic [N-1:0]    m_w_req,
   input  logic [N*AW-1:0] m_w_addr,
   input  logic [N*TW-1:0] m_w_type,
   input  logic [N*SW-1:0] m_w_strb,
   input  logic [N*DW-1:0] m_w_data,
   output logic [N-1:0]    m_w_rdy,
   output logic            s_r_req,
   output logic [AW-1:0]   s_r_addr,
   output logic [TW-1:0]   s_r_type,
   input  logic            s_r_rdy,
   input  logic [DW-1:0]   s_re_data,
   input  logic            s_re_valid,
   output logic            s_w_req,
   output logic [AW-1:0]   s_w_addr,
   output logic [TW-1:0]   s_w_type,
   output logic [SW-1:0]   s_w_strb,
   output logic [DW-1:0]   s_w_data,
   input  logic            s_w_rdy
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   rd_state_e     rstate_q, rstate_d;
   wr_state_e     wstate_q, wstate_d;
   logic [IW-1:0] rgnt_q, rgnt_d, rr_r_q, rr_r_d;
   logic [IW-1:0] wgnt_q, wgnt_d, rr_w_q, rr_w_d;

   logic [AW-1:0] r_addr_arr [N];
   logic [TW-1:0] r_type_arr [N];
   logic [AW-1:0] w_addr_arr [N];
   logic [TW-1:0] w_type_arr [N];
   logic [SW-1:0] w_strb_arr [N];
   logic [DW-1:0] w_data_arr [N];

   logic [N-1:0]  haz, r_elig, r_pick_gnt, w_pick_gnt;
   logic [IW-1:0] r_pick_idx, w_pick_idx;

   function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g);
      return (int'(g) >= N - 1) ? '0 : g + 1'b1;
   endfunction

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_mst
         assign r_addr_arr[gi] = m_r_addr[gi*AW +: AW];
         assign r_type_arr[gi] = m_r_type[gi*TW +: TW];
         assign w_addr_arr[gi] = m_w_addr[gi*AW +: AW];
         assign w_type_arr[gi] = m_w_type[gi*TW +: TW];
         assign w_strb_arr[gi] = m_w_strb[gi*SW +: SW];
         assign w_data_arr[gi] = m_w_data[gi*DW +: DW];
         // s_w_addr is only non-zero in W_REQ, i.e. while the write is still un-accepted
         assign haz[gi] = (wstate_q == W_REQ) &&
                          (r_addr_arr[gi][AW-1:LINE_OFS] == s_w_addr[AW-1:LINE_OFS]);
      end
   endgenerate

   assign r_elig = m_r_req & ~haz;

   mem_port_arbiter_rr_pick #(.N(N)) u_rd_pick (
      .req (r_elig),
      .ptr (rr_r_q),
      .gnt (r_pick_gnt),
      .idx (r_pick_idx)
   );

   mem_port_arbiter_rr_pick #(.N(N)) u_wr_pick (
      .req (m_w_req),
      .ptr (rr_w_q),
      .gnt (w_pick_gnt),
      .idx (w_pick_idx)
   );

   assign m_re_data = s_re_data;

   // Read channel
   always_comb begin
      rstate_d   = rstate_q;
      rgnt_d     = rgnt_q;
      rr_r_d     = rr_r_q;
      s_r_req    = 1'b0;
      s_r_addr   = '0;
      s_r_type   = '0;
      m_r_rdy    = '0;
      m_re_valid = '0;
      case (rstate_q)
         R_IDLE: begin
            if (|r_pick_gnt) begin
               rgnt_d   = r_pick_idx;
               rstate_d = R_REQ;
            end
         end
         R_REQ: begin
            s_r_req         = m_r_req[rgnt_q];
            s_r_addr        = r_addr_arr[rgnt_q];
            s_r_type        = r_type_arr[rgnt_q];
            m_r_rdy[rgnt_q] = s_r_rdy & m_r_req[rgnt_q];
            // A withdrawn request abandons the grant without moving the pointer
            if (!m_r_req[rgnt_q]) begin
               rstate_d = R_IDLE;
            end else if (s_r_rdy) begin
               rstate_d = R_DATA;
            end
         end
         R_DATA: begin
            m_re_valid[rgnt_q] = s_re_valid;
            if (s_re_valid) begin
               rstate_d = R_IDLE;
               rr_r_d   = rr_next(rgnt_q);
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   // Write channel
   always_comb begin
      wstate_d = wstate_q;
      wgnt_d   = wgnt_q;
      rr_w_d   = rr_w_q;
      s_w_req  = 1'b0;
      s_w_addr = '0;
      s_w_type = '0;
      s_w_strb = '0;
      s_w_data = '0;
      m_w_rdy  = '0;
      case (wstate_q)
         W_IDLE: begin
            if (|w_pick_gnt) begin
               wgnt_d   = w_pick_idx;
               wstate_d = W_REQ;
            end
         end
         W_REQ: begin
            s_w_req         = m_w_req[wgnt_q];
            s_w_addr        = w_addr_arr[wgnt_q];
            s_w_type        = w_type_arr[wgnt_q];
            s_w_strb        = w_strb_arr[wgnt_q];
            s_w_data        = w_data_arr[wgnt_q];
            m_w_rdy[wgnt_q] = s_w_rdy & m_w_req[wgnt_q];
            if (!m_w_req[wgnt_q]) begin
               wstate_d = W_IDLE;
            end else if (s_w_rdy) begin
               wstate_d = W_IDLE;
               rr_w_d   = rr_next(wgnt_q);
            end
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rstate_q <= R_IDLE;
         rgnt_q   <= '0;
         rr_r_q   <= '0;
         wstate_q <= W_IDLE;
         wgnt_q   <= '0;
         rr_w_q   <= '0;
      end else begin
         rstate_q <= rstate_d;
         rgnt_q   <= rgnt_d;
         rr_r_q   <= rr_r_d;
         wstate_q <= wstate_d;
         wgnt_q   <= wgnt_d;
         rr_w_q   <= rr_w_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 256;
   localparam int TW = 6;
   localparam int SW = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    m_r_req;
   logic [N*AW-1:0] m_r_addr;
   logic [N*TW-1:0] m_r_type;
   logic [N-1:0]    m_r_rdy;
   logic [DW-1:0]   m_re_data;
   logic [N-1:0]    m_re_valid;
   logic [N-1:0]    m_w_req;
   logic [N*AW-1:0] m_w_addr;
   logic [N*TW-1:0] m_w_type;
   logic [N*SW-1:0] m_w_strb;
   logic [N*DW-1:0] m_w_data;
   logic [N-1:0]    m_w_rdy;
   logic            s_r_req;
   logic [AW-1:0]   s_r_addr;
   logic [TW-1:0]   s_r_type;
   logic            s_r_rdy;
   logic [DW-1:0]   s_re_data;
   logic            s_re_valid;
   logic            s_w_req;
   logic [AW-1:0]   s_w_addr;
   logic [TW-1:0]   s_w_type;
   logic [SW-1:0]   s_w_strb;
   logic [DW-1:0]   s_w_data;
   logic            s_w_rdy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.N(N), .AW(AW), .DW(DW), .TW(TW), .SW(SW)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_r_req(m_r_req), .m_r_addr(m_r_addr), .m_r_type(m_r_type), .m_r_rdy(m_r_rdy),
      .m_re_data(m_re_data), .m_re_valid(m_re_valid),
      .m_w_req(m_w_req), .m_w_addr(m_w_addr), .m_w_type(m_w_type), .m_w_strb(m_w_strb),
      .m_w_data(m_w_data), .m_w_rdy(m_w_rdy),
      .s_r_req(s_r_req), .s_r_addr(s_r_addr), .s_r_type(s_r_type), .s_r_rdy(s_r_rdy),
      .s_re_data(s_re_data), .s_re_valid(s_re_valid),
      .s_w_req(s_w_req), .s_w_addr(s_w_addr), .s_w_type(s_w_type), .s_w_strb(s_w_strb),
      .s_w_data(s_w_data), .s_w_rdy(s_w_rdy)
   );

   // Inputs change 1 time unit after the rising edge; outputs are sampled a further #1 later.
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic set_r(input int m, input logic [AW-1:0] a);
      m_r_addr[m*AW +: AW] = a;
      m_r_type[m*TW +: TW] = TW'(m + 1);
   endtask

   task automatic set_w(input int m, input logic [AW-1:0] a, input logic [SW-1:0] st,
                        input logic [DW-1:0] d);
      m_w_addr[m*AW +: AW] = a;
      m_w_type[m*TW +: TW] = TW'(m + 9);
      m_w_strb[m*SW +: SW] = st;
      m_w_data[m*DW +: DW] = d;
   endtask

   task automatic wait_s_r_req;
      for (int k = 0; k < 12 && s_r_req !== 1'b1; k++) begin
         cyc;
         #1;
      end
   endtask

   // Bridge side of one read, starting in a cycle where s_r_req is visible.
   task automatic serve_read(input int m, input bit drop, input logic [DW-1:0] d);
      s_r_rdy = 1'b1;
      cyc;
      s_r_rdy = 1'b0;
      if (drop) m_r_req[m] = 1'b0;
      s_re_valid = 1'b1;
      s_re_data  = d;
      cyc;
      s_re_valid = 1'b0;
      #1;
   endtask

   function automatic logic [DW-1:0] rand_line();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic test_reset;
      #1;
      checks++;
      if ({s_r_req, s_w_req, m_r_rdy, m_w_rdy, m_re_valid} !== '0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=0", {s_r_req, s_w_req, m_r_rdy, m_w_rdy, m_re_valid});
      end
      checks++;
      if ({s_r_addr, s_r_type, s_w_addr, s_w_type, s_w_strb, s_w_data} !== '0) begin
         failures++;
         $display("FAIL reset_payload got nonzero exp=0");
      end
      repeat (3) cyc;
      rst_n = 1'b1;
      #1;
      checks++;
      if ({s_r_req, s_w_req} !== 2'b00) begin
         failures++;
         $display("FAIL reset_release got=%b exp=00", {s_r_req, s_w_req});
      end
      $display("test_reset done");
   endtask

   task automatic test_single_read;
      cyc;
      set_r(0, 32'h8000_0000);
      m_r_req = 3'b001;
      #1;
      checks++;
      if (s_r_req !== 1'b0) begin
         failures++; $display("FAIL rd_lat0 s_r_req=%b exp=0", s_r_req);
      end
      cyc; #1;
      checks++;
      if ({s_r_req, s_r_addr, s_r_type} !== {1'b1, 32'h8000_0000, 6'd1}) begin
         failures++;
         $display("FAIL rd_req got=%b/%h/%h exp=1/80000000/01", s_r_req, s_r_addr, s_r_type);
      end
      cyc; #1;
      checks++;
      if (m_r_rdy !== 3'b000) begin
         failures++; $display("FAIL rd_rdy_early got=%b exp=000", m_r_rdy);
      end
      cyc;
      s_r_rdy = 1'b1;
      #1;
      checks++;
      if (m_r_rdy !== 3'b001) begin
         failures++; $display("FAIL rd_rdy got=%b exp=001", m_r_rdy);
      end
      cyc;
      s_r_rdy = 1'b0;
      m_r_req = 3'b000;
      #1;
      checks++;
      if ({m_r_rdy, s_r_req} !== 4'b0000) begin
         failures++; $display("FAIL rd_rdy_pulse got=%b exp=0000", {m_r_rdy, s_r_req});
      end
      repeat (4) cyc;
      s_re_valid = 1'b1;
      s_re_data  = {32{8'hAB}};
      #1;
      checks++;
      if ({m_re_valid, m_re_data} !== {3'b001, {32{8'hAB}}}) begin
         failures++; $display("FAIL rd_resp valid=%b data=%h exp=001/ab..ab", m_re_valid, m_re_data);
      end
      cyc;
      s_re_valid = 1'b0;
      #1;
      checks++;
      if (m_re_valid !== 3'b000) begin
         failures++; $display("FAIL rd_resp_pulse got=%b exp=000", m_re_valid);
      end
      // pointer now 1: of masters {0,2}, master 2 must win
      set_r(0, 32'h8000_2000);
      set_r(2, 32'h8000_1000);
      m_r_req = 3'b101;
      wait_s_r_req;
      checks++;
      if ({s_r_req, s_r_addr} !== {1'b1, 32'h8000_1000}) begin
         failures++; $display("FAIL rd_rr_ptr got=%b/%h exp=1/80001000", s_r_req, s_r_addr);
      end
      serve_read(2, 1'b1, '0);
      m_r_req[0] = 1'b0;
      $display("test_single_read done");
   endtask

   task automatic test_contention;
      int order [4] = '{0, 1, 2, 0};
      for (int m = 0; m < N; m++) set_r(m, 32'h9000_0000 + 32'(m * 256));
      m_r_req = 3'b111;
      for (int t = 0; t < 4; t++) begin
         wait_s_r_req;
         checks++;
         if ({s_r_req, s_r_addr} !== {1'b1, 32'h9000_0000 + 32'(order[t] * 256)}) begin
            failures++;
            $display("FAIL contention_%0d got=%b/%h exp master %0d", t, s_r_req, s_r_addr, order[t]);
         end
         serve_read(order[t], 1'b0, rand_line());
      end
      m_r_req = 3'b000;
      cyc;
      $display("test_contention done");
   endtask

   task automatic test_hazard;
      bit seen;
      logic [DW-1:0] wd;
      wd = rand_line();
      set_w(1, 32'h8000_0040, 16'hF0F0, wd);
      m_w_req = 3'b010;
      cyc; #1;
      checks++;
      if ({s_w_req, s_w_addr, s_w_strb, s_w_type, s_w_data} !== {1'b1, 32'h8000_0040, 16'hF0F0, 6'd10, wd}) begin
         failures++; $display("FAIL wr_req got=%b/%h/%h/%h exp=1/80000040/f0f0/0a", s_w_req, s_w_addr, s_w_strb, s_w_type);
      end
      set_r(2, 32'h8000_0048);
      m_r_req = 3'b100;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (s_r_req === 1'b1) seen = 1'b1;
         cyc;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++; $display("FAIL hazard_block s_r_req seen=%b exp=0", seen);
      end
      s_w_rdy = 1'b1;
      #1;
      checks++;
      if ({m_w_rdy, s_r_req} !== 4'b0100) begin
         failures++; $display("FAIL hazard_wrdy got=%b exp=0100", {m_w_rdy, s_r_req});
      end
      cyc;
      s_w_rdy = 1'b0;
      m_w_req = 3'b000;
      #1;
      checks++;
      if ({m_w_rdy, s_r_req} !== 4'b0000) begin
         failures++; $display("FAIL hazard_grant_cycle got=%b exp=0000", {m_w_rdy, s_r_req});
      end
      cyc; #1;
      checks++;
      if ({s_r_req, s_r_addr} !== {1'b1, 32'h8000_0048}) begin
         failures++; $display("FAIL hazard_release got=%b/%h exp=1/80000048", s_r_req, s_r_addr);
      end
      serve_read(2, 1'b1, rand_line());
      // different line: not held off
      set_w(1, 32'h8000_0040, 16'h00FF, wd);
      m_w_req = 3'b010;
      cyc; #1;
      set_r(2, 32'h8000_0060);
      m_r_req = 3'b100;
      cyc; #1;
      checks++;
      if ({s_w_req, s_r_req, s_r_addr} !== {2'b11, 32'h8000_0060}) begin
         failures++; $display("FAIL hazard_other_line got=%b%b/%h exp=11/80000060", s_w_req, s_r_req, s_r_addr);
      end
      serve_read(2, 1'b1, rand_line());
      s_w_rdy = 1'b1;
      cyc;
      s_w_rdy = 1'b0;
      m_w_req = 3'b000;
      $display("test_hazard done");
   endtask

   task automatic test_abort;
      set_r(0, 32'h8000_0100);
      set_r(1, 32'h8000_0200);
      m_r_req = 3'b011;
      wait_s_r_req;
      checks++;
      if ({s_r_req, s_r_addr} !== {1'b1, 32'h8000_0100}) begin
         failures++; $display("FAIL abort_grant0 got=%b/%h exp=1/80000100", s_r_req, s_r_addr);
      end
      cyc;
      m_r_req[0] = 1'b0;
      #1;
      checks++;
      if ({s_r_req, m_r_rdy} !== 4'b0000) begin
         failures++; $display("FAIL abort_drop got=%b exp=0000", {s_r_req, m_r_rdy});
      end
      cyc; #1;
      checks++;
      if (s_r_req !== 1'b0) begin
         failures++; $display("FAIL abort_idle s_r_req=%b exp=0", s_r_req);
      end
      cyc; #1;
      checks++;
      if ({s_r_req, s_r_addr} !== {1'b1, 32'h8000_0200}) begin
         failures++; $display("FAIL abort_next got=%b/%h exp=1/80000200", s_r_req, s_r_addr);
      end
      serve_read(1, 1'b1, rand_line());
      $display("test_abort done");
   endtask

   task automatic test_parallel;
      logic [DW-1:0] d;
      d = rand_line();
      set_w(1, 32'h8000_4000, 16'hFFFF, rand_line());
      set_r(2, 32'h8000_5000);
      m_w_req = 3'b010;
      m_r_req = 3'b100;
      #1;
      checks++;
      if ({s_w_req, s_r_req} !== 2'b00) begin
         failures++; $display("FAIL par_cycle0 got=%b exp=00", {s_w_req, s_r_req});
      end
      cyc; #1;
      checks++;
      if ({s_w_req, s_r_req} !== 2'b11) begin
         failures++; $display("FAIL par_cycle1 got=%b exp=11", {s_w_req, s_r_req});
      end
      s_w_rdy = 1'b1;
      s_r_rdy = 1'b1;
      #1;
      checks++;
      if ({m_w_rdy, m_r_rdy} !== 6'b010100) begin
         failures++; $display("FAIL par_rdy got=%b exp=010100", {m_w_rdy, m_r_rdy});
      end
      cyc;
      s_w_rdy = 1'b0;
      s_r_rdy = 1'b0;
      m_w_req = 3'b000;
      m_r_req = 3'b000;
      s_re_valid = 1'b1;
      s_re_data  = d;
      #1;
      checks++;
      if ({m_re_valid, m_re_data} !== {3'b100, d}) begin
         failures++; $display("FAIL par_resp valid=%b exp=100", m_re_valid);
      end
      cyc;
      s_re_valid = 1'b0;
      $display("test_parallel done");
   endtask

   task automatic test_reset_mid;
      bit seen;
      set_r(0, 32'h8000_8000);
      set_w(2, 32'h8000_7000, 16'h1234, rand_line());
      m_r_req = 3'b001;
      m_w_req = 3'b100;
      wait_s_r_req;
      s_r_rdy = 1'b1;
      cyc;
      s_r_rdy = 1'b0;
      m_r_req = 3'b000;
      #2;
      s_re_valid = 1'b1;
      s_w_rdy    = 1'b1;
      rst_n      = 1'b0;
      #1;
      checks++;
      if ({s_w_req, m_w_rdy, m_re_valid, s_r_req, m_r_rdy} !== '0) begin
         failures++;
         $display("FAIL reset_async ctrl=%b exp=0", {s_w_req, m_w_rdy, m_re_valid, s_r_req, m_r_rdy});
      end
      checks++;
      if ({s_w_addr, s_w_strb, s_w_data, s_w_type} !== '0) begin
         failures++; $display("FAIL reset_async_payload addr=%h strb=%h exp=0", s_w_addr, s_w_strb);
      end
      m_w_req = 3'b000;
      s_w_rdy = 1'b0;
      cyc; cyc;
      #2;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc; #1;
         if (m_re_valid !== 3'b000) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++; $display("FAIL reset_stale_resp seen=%b exp=0", seen);
      end
      s_re_valid = 1'b0;
      set_r(1, 32'h8000_9000);
      m_r_req = 3'b011;
      wait_s_r_req;
      checks++;
      if ({s_r_req, s_r_addr} !== {1'b1, 32'h8000_8000}) begin
         failures++; $display("FAIL reset_regrant got=%b/%h exp=1/80008000", s_r_req, s_r_addr);
      end
      serve_read(0, 1'b1, rand_line());
      wait_s_r_req;
      serve_read(1, 1'b1, rand_line());
      $display("test_reset_mid done");
   endtask

   // Transaction-level model: pending set + pointer; winner is the first pending
   // master at or after the pointer; pointer moves past the winner on completion.
   task automatic test_random_reads;
      logic [AW-1:0] exp_addr [N];
      logic [N-1:0]  oh;
      logic [DW-1:0] d;
      int rr_model;
      int exp_m;
      cyc;
      rst_n = 1'b0;
      m_r_req = '0;
      cyc;
      rst_n = 1'b1;
      rr_model = 0;
      for (int t = 0; t < 40; t++) begin
         for (int m = 0; m < N; m++) begin
            if (!m_r_req[m] && ($urandom_range(0, 1) == 1)) begin
               exp_addr[m] = $urandom;
               set_r(m, exp_addr[m]);
               m_r_req[m] = 1'b1;
            end
         end
         if (m_r_req == '0) begin
            exp_addr[t % N] = $urandom;
            set_r(t % N, exp_addr[t % N]);
            m_r_req[t % N] = 1'b1;
         end
         exp_m = -1;
         for (int k = 0; k < N; k++) begin
            if (exp_m < 0 && m_r_req[(rr_model + k) % N]) exp_m = (rr_model + k) % N;
         end
         oh = '0;
         oh[exp_m] = 1'b1;
         wait_s_r_req;
         checks++;
         if ({s_r_req, s_r_addr, s_r_type} !== {1'b1, exp_addr[exp_m], TW'(exp_m + 1)}) begin
            failures++;
            $display("FAIL rand_grant_%0d got=%b/%h exp master %0d addr %h", t, s_r_req, s_r_addr, exp_m, exp_addr[exp_m]);
         end
         repeat ($urandom_range(0, 3)) cyc;
         s_r_rdy = 1'b1;
         #1;
         checks++;
         if (m_r_rdy !== oh) begin
            failures++; $display("FAIL rand_rdy_%0d got=%b exp=%b", t, m_r_rdy, oh);
         end
         cyc;
         s_r_rdy = 1'b0;
         m_r_req[exp_m] = 1'b0;
         repeat ($urandom_range(0, 3)) cyc;
         d = rand_line();
         s_re_valid = 1'b1;
         s_re_data  = d;
         #1;
         checks++;
         if ({m_re_valid, m_re_data} !== {oh, d}) begin
            failures++; $display("FAIL rand_resp_%0d valid=%b exp=%b", t, m_re_valid, oh);
         end
         cyc;
         s_re_valid = 1'b0;
         rr_model = (exp_m + 1) % N;
      end
      m_r_req = '0;
      $display("test_random_reads done");
   endtask

   initial begin
      rst_n      = 1'b0;
      m_r_req    = '0;
      m_r_addr   = '0;
      m_r_type   = '0;
      m_w_req    = '0;
      m_w_addr   = '0;
      m_w_type   = '0;
      m_w_strb   = '0;
      m_w_data   = '0;
      s_r_rdy    = 1'b0;
      s_re_data  = '0;
      s_re_valid = 1'b0;
      s_w_rdy    = 1'b0;
      test_reset;
      test_single_read;
      test_contention;
      test_hazard;
      test_abort;
      test_parallel;
      test_reset_mid;
      test_random_reads;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
